// File: rtl/wb_trace_fifo.sv
// Commit-trace FWFT FIFO behind the write-back stage: captures {pc, addr, data}, drains over valid/ready.
// Optional build macro WB_TRACE_ZERO_FILTER_EN drops writes to $0 before they reach the FIFO.
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_addr,
    output logic [31:0]      out_data,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [68:0]      mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             overflow_reg;
    logic [7:0]       drop_cnt_reg;
    logic             filter_ok;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic [68:0]      head;

`ifdef WB_TRACE_ZERO_FILTER_EN
    assign filter_ok = (wb_addr != 5'd0);
`else
    assign filter_ok = 1'b1;
`endif

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign push_req  = wb_valid && filter_ok;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push      = push_req && ((count_reg != FULL_COUNT) || pop);
    assign drop      = push_req && (count_reg == FULL_COUNT) && !pop;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    // Storage is intentionally left unreset; the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_reg[wr_ptr_reg] <= {wb_pc, wb_addr, wb_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 8'hFF)
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign head     = mem_reg[rd_ptr_reg];
    assign out_pc   = out_valid ? head[68:37] : 32'd0;
    assign out_addr = out_valid ? head[36:32] : 5'd0;
    assign out_data = out_valid ? head[31:0]  : 32'd0;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Commit-trace buffer that sits directly downstream of the `mips` core's write-back stage. It captures every architectural register-file write (PC, destination register, data) in a small first-word-fall-through FIFO and drains the entries to a checker or trace sink over a valid/ready handshake. It also reports occupancy and sticky overflow status. Entries are never reordered, and writes are never silently merged.

## Interface
Parameters:
- `DEPTH`, 8: number of FIFO entries; must be a power of two, ≥2.
- `PTR_W`, 3: log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is sampled by `clk`.
- `wb_valid`  in  1  the core commits a register write this cycle.
- `wb_pc`  in  32  PC of the committing instruction.
- `wb_addr`  in  5  destination GPR number.
- `wb_data`  in  32  value written.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  sink accepts the head entry this cycle.
- `out_pc`  out  32  head entry PC.
- `out_addr`  out  5  head entry register.
- `out_data`  out  32  head entry data.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: an entry was dropped because the FIFO was full.
- `drop_cnt`  out  8  number of dropped entries, saturating at 255.

## Operation
- Storage: `DEPTH` × 69-bit entries {pc, addr, data}, plus write and read pointers of `PTR_W` bits that wrap modulo `DEPTH`. Occupancy is held in `count`.
- Push condition: `wb_valid` is 1, the entry passes the filter (see Configuration), and either `count < DEPTH` or a pop happens in the same cycle.
- Pop condition: `out_valid && out_ready`.
- `out_valid` = (`count != 0`).
- `out_pc`, `out_addr` and `out_data` show the entry at the read pointer. They are driven from the storage array (first-word fall-through). When `count == 0` they are 0.
- Push and pop in the same cycle:
  - `count` is unchanged.
  - Both pointers advance.
  - This is legal at any occupancy, including full and empty. When empty, the push and pop cannot coincide because `out_valid` is 0.
- Overflow, i.e. a push is requested with `count == DEPTH` and no pop:
  - The entry is discarded.
  - `overflow` is set to 1 and stays at 1 until reset.
  - `drop_cnt` increments and saturates at 255.
  - The stored entries and the pointers are unchanged.
- The sink holding `out_ready` low indefinitely is legal. The head entry stays stable until it is popped.
- `out_ready` asserted while `out_valid` is 0 has no effect.

## Timing
- Reset values: `out_valid`=0, `out_pc`=0, `out_addr`=0, `out_data`=0, `count`=0, `overflow`=0, `drop_cnt`=0. Both pointers are 0.
- Storage contents are not reset. The head outputs are masked to 0 while `count==0`.
- Latency: a push sampled at edge N appears on `out_*` with `out_valid`=1 after edge N. This is one cycle of latency, with no extra bubble.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-operation: all entries are discarded and the outputs take their reset values asynchronously, without waiting for a clock edge. The first push after release is accepted on the first rising edge where `reset`=1.

## Configuration
- Macro `WB_TRACE_ZERO_FILTER_EN`.
- Defined: writes with `wb_addr == 0` are treated as no push. They do not occupy entries and never cause overflow.
- Undefined: every `wb_valid` cycle is a push candidate, including writes to `$0`, so the sink sees the raw write-back stream.

## Test plan
- Reset then single write:
  - Stimulus: hold `reset`=0 for 3 cycles, release, then a single `wb_valid` with pc=0x00003000, addr=8, data=0x12345678, while `out_ready`=0.
  - Required response: on the next cycle `out_valid`=1, `out_pc`=0x00003000, `out_addr`=8, `out_data`=0x12345678, `count`=1. These hold until `out_ready` is driven to 1.
- Fill and overflow:
  - Stimulus: with `out_ready`=0, apply 10 consecutive pushes with data 1..10 (`DEPTH`=8).
  - Required response: `count`=8, `overflow`=1, `drop_cnt`=2. Draining then yields data 1..8 in order, after which `out_valid`=0.
- Full plus simultaneous push/pop:
  - Stimulus: fill to 8, then one cycle with `wb_valid`=1 (data 0xAA) and `out_ready`=1.
  - Required response: `count` stays 8, `overflow` stays 0, and 0xAA appears as the 8th entry drained after the current head.
- Streaming with pointer wrap:
  - Stimulus: hold `out_ready`=1 and push 20 consecutive entries.
  - Required response: each entry appears exactly one cycle after its push, `count` never exceeds 1, and all 20 are received in order.
- Filter:
  - Stimulus: push addr=0 data=5, then addr=3 data=6.
  - Required response with `WB_TRACE_ZERO_FILTER_EN` defined: only addr=3 is output and `count` peaks at 1.
  - Required response without the macro: both entries are output, in order.
- Asynchronous reset mid-drain:
  - Stimulus: with 5 entries stored, assert `reset`=0 between clock edges.
  - Required response: `out_valid`, `count`, `overflow` and `drop_cnt` go to 0 immediately, before the next clock edge.
